// File: rtl/serial_operand_loader_pkg.sv
// Shared types and helpers for the serial operand loader.
// Optional feature macro used by this slice: SERIAL_SUM_CAPTURE_EN.
package serial_pkg;

    localparam int SERIAL_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } serial_state_e;

    // Bit-counter width; a one-bit operand still needs a one-bit counter.
    function automatic int serial_cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_operand_loader_if.sv
// Handshake and serial-adder bundle for serial_operand_loader.
// Capture ports exist only when SERIAL_SUM_CAPTURE_EN is defined.
interface serial_operand_loader_if #(
    parameter int WIDTH = serial_pkg::SERIAL_WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             a;
    logic             b;
    logic             cin;
    logic             adder_reset;
    logic             busy;
    logic             last;
    logic             done;
`ifdef SERIAL_SUM_CAPTURE_EN
    logic             s;
    logic             cout;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
    logic             sum_valid;

    modport master (
        output in_valid, op_a, op_b, op_cin, s, cout,
        input  in_ready, a, b, cin, adder_reset, busy, last, done,
               sum_out, cout_out, sum_valid
    );
    modport slave (
        input  in_valid, op_a, op_b, op_cin, s, cout,
        output in_ready, a, b, cin, adder_reset, busy, last, done,
               sum_out, cout_out, sum_valid
    );
`else
    modport master (
        output in_valid, op_a, op_b, op_cin,
        input  in_ready, a, b, cin, adder_reset, busy, last, done
    );
    modport slave (
        input  in_valid, op_a, op_b, op_cin,
        output in_ready, a, b, cin, adder_reset, busy, last, done
    );
`endif
endinterface

// File: rtl/piso_shreg.sv
// Parallel-load, shift-right (zero-fill) register; bit 0 is the serial output.
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit
);
    logic [WIDTH-1:0] r_data;

    // Load has priority over shift; otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= r_data >> 1'b1;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_bit = r_data[0];
endmodule

// File: rtl/serial_operand_loader.sv
// Parallel-to-serial front end for a bit-serial adder.
// Define SERIAL_SUM_CAPTURE_EN to also collect s/cout into a parallel result.
// Output bits are registered one cycle after the shift register presents them,
// so the operand registers shift on the CLEAR edge and on every non-final
// SHIFT edge.
module serial_operand_loader
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_operand_loader_if.slave  bus
);
    localparam int            CW       = serial_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    serial_state_e r_state;
    serial_state_e w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_cin_lat;
    logic          w_load;
    logic          w_shift;
    logic          w_a_bit;
    logic          w_b_bit;
    logic          w_a;
    logic          w_b;
    logic          w_cin;
    logic          w_adder_reset;
    logic          w_last;
    logic          w_done;
    logic          r_a;
    logic          r_b;
    logic          r_cin;
    logic          r_adder_reset;
    logic          r_busy;
    logic          r_last;
    logic          r_done;

    piso_shreg #(.WIDTH(WIDTH)) u_sr_a (
        .clk(clk), .reset(reset), .i_load(w_load), .i_shift(w_shift),
        .i_data(bus.op_a), .o_bit(w_a_bit)
    );

    piso_shreg #(.WIDTH(WIDTH)) u_sr_b (
        .clk(clk), .reset(reset), .i_load(w_load), .i_shift(w_shift),
        .i_data(bus.op_b), .o_bit(w_b_bit)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        w_a           = 1'b0;
        w_b           = 1'b0;
        w_cin         = 1'b0;
        w_adder_reset = 1'b0;
        w_last        = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_load        = 1'b1;
                    w_adder_reset = 1'b1;
                    w_state_nxt   = CLEAR;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            CLEAR: begin
                w_state_nxt = SHIFT;
                w_cnt_nxt   = '0;
                w_shift     = 1'b1;
                w_a         = w_a_bit;
                w_b         = w_b_bit;
                w_cin       = r_cin_lat;
                w_last      = (LAST_CNT == '0);
            end
            SHIFT: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = DONE;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_shift     = 1'b1;
                    w_a         = w_a_bit;
                    w_b         = w_b_bit;
                    w_last      = (w_cnt_nxt == LAST_CNT);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Counter, latched carry-in and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_cin_lat     <= 1'b0;
            r_a           <= 1'b0;
            r_b           <= 1'b0;
            r_cin         <= 1'b0;
            r_adder_reset <= 1'b0;
            r_busy        <= 1'b0;
            r_last        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_cin_lat     <= w_load ? bus.op_cin : r_cin_lat;
            r_a           <= w_a;
            r_b           <= w_b;
            r_cin         <= w_cin;
            r_adder_reset <= w_adder_reset;
            r_busy        <= (w_state_nxt != IDLE);
            r_last        <= w_last;
            r_done        <= w_done;
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.a           = r_a;
    assign bus.b           = r_b;
    assign bus.cin         = r_cin;
    assign bus.adder_reset = r_adder_reset;
    assign bus.busy        = r_busy;
    assign bus.last        = r_last;
    assign bus.done        = r_done;

`ifdef SERIAL_SUM_CAPTURE_EN
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_cout_out;
    logic             r_sum_valid;
    logic [WIDTH-1:0] w_sum_shift;

    // s of each bit enters at the MSB so bit 0 ends up at the LSB.
    assign w_sum_shift = WIDTH'({bus.s, r_sum_sr} >> 1'b1);

    // Sum collection: cleared on accept, shifted on every SHIFT edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum_sr    <= '0;
            r_cout_out  <= 1'b0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= w_done;
            if (w_load) begin
                r_sum_sr <= '0;
            end else if (r_state == SHIFT) begin
                r_sum_sr <= w_sum_shift;
            end else begin
                r_sum_sr <= r_sum_sr;
            end
            r_cout_out <= w_done ? bus.cout : r_cout_out;
        end
    end

    assign bus.sum_out   = r_sum_sr;
    assign bus.cout_out  = r_cout_out;
    assign bus.sum_valid = r_sum_valid;
`endif

endmodule

// File: tb/tb_serial_operand_loader.sv
// Self-checking bench for serial_operand_loader (WIDTH=8 main instance and a
// WIDTH=1 instance). Capture checks are active when SERIAL_SUM_CAPTURE_EN is set.
module tb_serial_operand_loader;
    import serial_pkg::*;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    serial_operand_loader_if #(.WIDTH(W)) bus8 ();
    serial_operand_loader_if #(.WIDTH(1)) bus1 ();

    serial_operand_loader #(.WIDTH(W)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    serial_operand_loader #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // Bit-serial adder models: carry flop cleared by adder_reset, cin ORed in.
    logic c8_r, c1_r, ci8, ci1, co8, co1;
    assign ci8 = c8_r | bus8.cin;
    assign ci1 = c1_r | bus1.cin;
    assign co8 = (bus8.a & bus8.b) | (ci8 & (bus8.a ^ bus8.b));
    assign co1 = (bus1.a & bus1.b) | (ci1 & (bus1.a ^ bus1.b));
`ifdef SERIAL_SUM_CAPTURE_EN
    assign bus8.s    = bus8.a ^ bus8.b ^ ci8;
    assign bus8.cout = co8;
    assign bus1.s    = bus1.a ^ bus1.b ^ ci1;
    assign bus1.cout = co1;
`endif

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            c8_r <= 1'b0;
            c1_r <= 1'b0;
        end else begin
            c8_r <= bus8.adder_reset ? 1'b0 : co8;
            c1_r <= bus1.adder_reset ? 1'b0 : co1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle offset since accept (0 = idle) and the latched op.
    int             m_k = 0;
    logic [W-1:0]   m_a, m_b;
    logic           m_c;
    logic [W:0]     m_total;
    logic [W-1:0]   m_sum_hold;
    logic           m_cout_hold;

    assign m_total = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_c};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_k         <= 0;
            m_a         <= '0;
            m_b         <= '0;
            m_c         <= 1'b0;
            m_sum_hold  <= '0;
            m_cout_hold <= 1'b0;
        end else if (m_k == 0) begin
            if (bus8.in_valid) begin
                m_k <= 1;
                m_a <= bus8.op_a;
                m_b <= bus8.op_b;
                m_c <= bus8.op_cin;
            end
        end else if (m_k == W + 2) begin
            m_k <= 0;
        end else begin
            if (m_k == W + 1) begin
                m_sum_hold  <= m_total[W-1:0];
                m_cout_hold <= m_total[W];
            end
            m_k <= m_k + 1;
        end
    end

    // Per-cycle comparison of the WIDTH=8 instance against the model.
    always @(negedge clk) begin : cmp
        int   k;
        logic ea, eb, ec;
        k  = m_k;
        ea = 1'b0;
        eb = 1'b0;
        ec = 1'b0;
        if (k >= 2 && k <= W + 1) begin
            ea = m_a[k-2];
            eb = m_b[k-2];
            ec = (k == 2) ? m_c : 1'b0;
        end
        chk("in_ready",    bus8.in_ready,    32'(k == 0));
        chk("adder_reset", bus8.adder_reset, 32'(k == 1));
        chk("busy",        bus8.busy,        32'(k != 0));
        chk("a",           bus8.a,           32'(ea));
        chk("b",           bus8.b,           32'(eb));
        chk("cin",         bus8.cin,         32'(ec));
        chk("last",        bus8.last,        32'(k == W + 1));
        chk("done",        bus8.done,        32'(k == W + 2));
`ifdef SERIAL_SUM_CAPTURE_EN
        chk("sum_valid",   bus8.sum_valid,   32'(k == W + 2));
        if (k == 0 || k == W + 2) begin
            chk("sum_out",  bus8.sum_out,  32'(m_sum_hold));
            chk("cout_out", bus8.cout_out, 32'(m_cout_hold));
        end
`endif
    end

    // Present an operation; returns number of cycles waited until accept.
    task automatic send8(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input bit keep_valid, output int waited);
        bit accepted;
        bus8.in_valid = 1'b1;
        bus8.op_a     = a;
        bus8.op_b     = b;
        bus8.op_cin   = c;
        accepted      = 1'b0;
        waited        = 0;
        while (!accepted && waited < 40) begin
            waited++;
            @(negedge clk);
            accepted = bus8.in_ready;
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 32'(accepted), 32'd1);
        if (!keep_valid) begin
            bus8.in_valid = 1'b0;
        end
    endtask

    // Record per-cycle observations for cycles 1..12 after an accept edge.
    task automatic observe8(output logic [W-1:0] av, output logic [W-1:0] bv,
                            output logic [15:0] cin_m, output logic [15:0] last_m,
                            output logic [15:0] done_m, output logic [15:0] adr_m);
        av = '0; bv = '0; cin_m = '0; last_m = '0; done_m = '0; adr_m = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            #1;
            if (c >= 2 && c <= W + 1) begin
                av[c-2] = bus8.a;
                bv[c-2] = bus8.b;
            end
            cin_m[c]  = bus8.cin;
            last_m[c] = bus8.last;
            done_m[c] = bus8.done;
            adr_m[c]  = bus8.adder_reset;
        end
    endtask

    initial begin
        int           n;
        logic [W-1:0] av, bv;
        logic [15:0]  cin_m, last_m, done_m, adr_m;

        bus8.in_valid = 1'b0; bus8.op_a = '0; bus8.op_b = '0; bus8.op_cin = 1'b0;
        bus1.in_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.op_cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // WIDTH=1: single SHIFT cycle carrying a, b, cin and last together.
        bus1.in_valid = 1'b1; bus1.op_a = 1'b1; bus1.op_b = 1'b1; bus1.op_cin = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        chk("w1_c1_adder_reset", 32'(bus1.adder_reset), 32'd1);
        chk("w1_c1_ready",       32'(bus1.in_ready),    32'd0);
        @(negedge clk);
        chk("w1_c2_abcl", {28'd0, bus1.a, bus1.b, bus1.cin, bus1.last}, 32'hF);
        @(negedge clk);
        chk("w1_c3_done", 32'(bus1.done), 32'd1);
`ifdef SERIAL_SUM_CAPTURE_EN
        chk("w1_sum",  32'(bus1.sum_out),  32'd1);
        chk("w1_cout", 32'(bus1.cout_out), 32'd1);
`endif
        @(negedge clk);
        chk("w1_c4_ready", {30'd0, bus1.in_ready, bus1.busy}, 32'h2);
        @(posedge clk); #1;

        // A5 + 3C, cin 0.
        send8(8'hA5, 8'h3C, 1'b0, 1'b0, n);
        observe8(av, bv, cin_m, last_m, done_m, adr_m);
        chk("a5_a_seq",     32'(av),     32'h0A5);
        chk("a5_b_seq",     32'(bv),     32'h03C);
        chk("a5_adr_cycle", 32'(adr_m),  32'h0002);
        chk("a5_done_cyc",  32'(done_m), 32'h0400);
`ifdef SERIAL_SUM_CAPTURE_EN
        chk("a5_sum",  32'(bus8.sum_out),  32'h0E1);
        chk("a5_cout", 32'(bus8.cout_out), 32'd0);
`endif

        // FF + 01: carry out, last only in cycle 9.
        send8(8'hFF, 8'h01, 1'b0, 1'b0, n);
        observe8(av, bv, cin_m, last_m, done_m, adr_m);
        chk("ff_last_cycle", 32'(last_m), 32'h0200);
`ifdef SERIAL_SUM_CAPTURE_EN
        chk("ff_sum",  32'(bus8.sum_out),  32'h000);
        chk("ff_cout", 32'(bus8.cout_out), 32'd1);
`endif

        // 00 + 00 + cin: cin only in cycle 2.
        send8(8'h00, 8'h00, 1'b1, 1'b0, n);
        observe8(av, bv, cin_m, last_m, done_m, adr_m);
        chk("cin_cycle", 32'(cin_m), 32'h0004);
`ifdef SERIAL_SUM_CAPTURE_EN
        chk("cin_sum",  32'(bus8.sum_out),  32'h001);
        chk("cin_cout", 32'(bus8.cout_out), 32'd0);
`endif

        // Two queued operations with in_valid held high.
        send8(8'h11, 8'h22, 1'b1, 1'b1, n);
        send8(8'h9C, 8'h47, 1'b0, 1'b0, n);
        chk("b2b_wait", 32'(n), 32'd11);
        observe8(av, bv, cin_m, last_m, done_m, adr_m);
        chk("b2b_a_seq", 32'(av), 32'h09C);

        // Reset during bit 4.
        send8(8'hC3, 8'h5A, 1'b1, 1'b0, n);
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_outputs", {25'd0, bus8.a, bus8.b, bus8.cin, bus8.last, bus8.done,
                            bus8.busy, bus8.in_ready}, 32'h1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        send8(8'h12, 8'h34, 1'b0, 1'b0, n);
        observe8(av, bv, cin_m, last_m, done_m, adr_m);
`ifdef SERIAL_SUM_CAPTURE_EN
        chk("post_rst_sum", 32'(bus8.sum_out), 32'h046);
`else
        chk("post_rst_a_seq", 32'(av), 32'h012);
`endif

        // Randomized operations with random gaps and back-to-back bursts.
        for (int i = 0; i < 40; i++) begin
            send8(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), n);
            if (!bus8.in_valid) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        bus8.in_valid = 1'b0;
        repeat (14) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_operand_loader.md
# serial_operand_loader

Parallel-to-serial front end for the bit-serial adder. Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. Clears the adder's carry state, then streams the operands LSB-first onto the adder's `a`/`b`/`cin` inputs, one bit per clock. Optionally it also collects the adder's `s`/`cout` back into a parallel result.

## Interface
- `WIDTH`, 8, operand width in bits; legal range is 1 and above.
- `clk`  in  1  rising-edge clock, shared with the serial adder.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has an operand pair.
- `in_ready`  out  1  loader can accept; high only in IDLE.
- `op_a`, `op_b`  in  WIDTH  parallel operands; sampled only on handshake.
- `op_cin`  in  1  carry-in for the operation; sampled only on handshake.
- `a`, `b`  out  1  serial operand bits to the adder, LSB first.
- `cin`  out  1  to the adder; equals the latched `op_cin` on the first bit, 0 on all other bits.
- `adder_reset`  out  1  active-high one-cycle clear of the adder's carry flop.
- `busy`  out  1  high in CLEAR, SHIFT and DONE.
- `last`  out  1  high during the final SHIFT cycle.
- `done`  out  1  one-cycle pulse after the final bit.
- `s`, `cout`  in  1  adder outputs. Present only with SUM_CAPTURE_EN.
- `sum_out`  out  WIDTH  captured sum. Present only with SUM_CAPTURE_EN.
- `cout_out`  out  1  captured carry-out. Present only with SUM_CAPTURE_EN.
- `sum_valid`  out  1  pulse coincident with `done`. Present only with SUM_CAPTURE_EN.

## Operation
- FSM states: IDLE, CLEAR, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `op_a`/`op_b` into shift registers, latch `op_cin`, then go to CLEAR.
- CLEAR:
  - `adder_reset`=1; `a`=`b`=`cin`=0.
  - Bit counter cleared; next state is SHIFT.
- SHIFT:
  - `a`/`b` = bit 0 of their shift registers.
  - `cin` = latched carry when count==0, otherwise 0.
  - Each edge shifts both registers right (zero-fill) and increments the counter.
  - `last`=1 when count==WIDTH-1; the next state is then DONE.
- DONE: `done`=1 and `a`/`b`/`cin`=0 for one cycle; next state is IDLE.
- All outputs except `in_ready` are registered. `in_ready` is decoded from state only, with no path from `in_valid`.
- `in_valid` is ignored while busy. Upstream holds its operands until accepted.
- Reset values: state IDLE, `in_ready`=1, all other outputs 0, `sum_out`=0, `cout_out`=0, shift registers and counter 0.
- Reset asserted mid-operation: outputs go to reset values immediately. No `done` or `sum_valid` pulse is produced. The operation is discarded.
- WIDTH=1: exactly one SHIFT cycle, with `last`=1 and `cin` active in it.

## Timing
- Accept edge = edge 0.
- Cycle 1: CLEAR.
- Cycles 2..WIDTH+1: bits 0..WIDTH-1 are on `a`/`b`.
- Cycle WIDTH+2: DONE.
- Cycle WIDTH+3: `in_ready`=1 again.
- Throughput: one operation per WIDTH+3 cycles with `in_valid` held high.
- The adder is treated as presenting `s` for bit i combinationally in the same cycle as bit i. `s` is sampled at the edge ending that SHIFT cycle.
- `cout` is sampled at the edge ending the `last` cycle.

## Configuration
- `SERIAL_SUM_CAPTURE_EN` defined:
  - The `s`/`cout` inputs and `sum_out`/`cout_out`/`sum_valid` outputs exist.
  - Each SHIFT edge does `sum_sr <= {s, sum_sr[WIDTH-1:1]}`.
  - `cout_out` is registered on the `last` edge.
  - `sum_out`/`cout_out` hold their value until the next accept edge.
- Undefined: those ports and registers are absent. The block is a pure loader.

## Structure
- Package `serial_pkg`:
  - FSM state typedef (IDLE/CLEAR/SHIFT/DONE).
  - `SERIAL_WIDTH_DEFAULT` = 8.
  - Counter-width function `$clog2(WIDTH)` with a minimum of 1.
- Sub-module `piso_shreg`: WIDTH-bit parallel-load, shift-right register with a serial bit-0 output. Instantiated twice, for `op_a` and `op_b`.

## Test plan
- WIDTH=8, `op_a`=8'hA5, `op_b`=8'h3C, `op_cin`=0:
  - `a` = 1,0,1,0,0,1,0,1 in cycles 2..9.
  - `b` = 0,0,1,1,1,1,0,0 in cycles 2..9.
  - `adder_reset` in cycle 1; `done` in cycle 10.
  - With capture: `sum_out`=8'hE1, `cout_out`=0.
- `op_a`=8'hFF, `op_b`=8'h01, `op_cin`=0 -> `sum_out`=8'h00, `cout_out`=1, `last` high only in cycle 9.
- `op_a`=8'h00, `op_b`=8'h00, `op_cin`=1 -> `cin`=1 only in cycle 2 -> `sum_out`=8'h01, `cout_out`=0.
- `in_valid` held high with two queued operations -> `in_ready` is low for cycles 1..10. The second operation is accepted at the edge ending cycle 11, and its data appears on `a`/`b` from cycle 13.
- Reset pulled low during bit 4 -> `a`/`b`/`cin`/`last`/`done` go to 0 at once and no `sum_valid` pulse occurs. `in_ready`=1 after release. The next operation (8'h12 + 8'h34) yields 8'h46.
- WIDTH=1, `op_a`=1, `op_b`=1, `op_cin`=1 -> a single SHIFT cycle with `a`=`b`=`cin`=`last`=1 -> `sum_out`=1, `cout_out`=1, `done` in cycle 3.
